// File: rtl/tpmem_pp.sv
// Ping-pong N x N transpose memory: rows are written into one bank while the other drains columns.
// Optional `TPMEM_PP_MODE_EN adds i_mode, a per-block pass-through select.
module tpmem_pp #(
    parameter int BW = 12,
    parameter int N  = 8
) (
    input  logic            i_clk,
    input  logic            i_Reset,
    input  logic [N*BW-1:0] i_data,
    input  logic            i_valid,
    output logic            o_ready,
`ifdef TPMEM_PP_MODE_EN
    input  logic            i_mode,
`endif
    output logic [N*BW-1:0] o_data,
    output logic            o_valid,
    output logic            o_last,
    input  logic            i_ready
);

    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    logic [N*BW-1:0] r_mem [2][N];
    logic [1:0]      r_full;
    logic [1:0]      w_full_d;
    logic            r_wr_bank;
    logic            r_rd_bank;
    logic [AW-1:0]   r_wr_row;
    logic [AW-1:0]   r_rd_col;
    logic            w_wr_en;
    logic            w_ld_en;
    logic [N*BW-1:0] w_col;
    logic [N*BW-1:0] w_rd_beat;
`ifdef TPMEM_PP_MODE_EN
    logic [1:0]      r_mode;
`endif

    assign o_ready = ~r_full[r_wr_bank];
    assign w_wr_en = i_valid & o_ready;
    assign w_ld_en = r_full[r_rd_bank] & (~o_valid | i_ready);

    // Element r of the output beat is element rd_col of row r.
    always_comb begin
        w_col = '0;
        for (int r = 0; r < N; r++) begin
            w_col[(N-1-r)*BW +: BW] = r_mem[r_rd_bank][r][(N-1-int'(r_rd_col))*BW +: BW];
        end
    end

`ifdef TPMEM_PP_MODE_EN
    assign w_rd_beat = r_mode[r_rd_bank] ? r_mem[r_rd_bank][r_rd_col] : w_col;
`else
    assign w_rd_beat = w_col;
`endif

    // Set and clear can only coincide on different banks, so both apply.
    always_comb begin
        w_full_d = r_full;
        if (w_wr_en && (r_wr_row == LAST)) w_full_d[r_wr_bank] = 1'b1;
        if (w_ld_en && (r_rd_col == LAST)) w_full_d[r_rd_bank] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[r_wr_bank][r_wr_row] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_Reset) begin
        if (!i_Reset) begin
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_row  <= '0;
            r_rd_col  <= '0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
`ifdef TPMEM_PP_MODE_EN
            r_mode    <= '0;
`endif
        end else begin
            r_full <= w_full_d;
            if (w_wr_en) begin
                if (r_wr_row == LAST) begin
                    r_wr_row  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_row <= r_wr_row + AW'(1);
                end
            end
`ifdef TPMEM_PP_MODE_EN
            if (w_wr_en && (r_wr_row == '0)) r_mode[r_wr_bank] <= i_mode;
`endif
            if (w_ld_en) begin
                o_data  <= w_rd_beat;
                o_valid <= 1'b1;
                o_last  <= (r_rd_col == LAST);
                if (r_rd_col == LAST) begin
                    r_rd_col  <= '0;
                    r_rd_bank <= ~r_rd_bank;
                end else begin
                    r_rd_col <= r_rd_col + AW'(1);
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
                o_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tpmem_pp.sv
// Directed bench for tpmem_pp: an N=8/BW=12 instance for the block-level tests and an
// N=4/BW=8 instance for the randomised handshake run.
module tb_tpmem_pp;

    localparam int BW = 12;
    localparam int N = 8;
    localparam int W = N * BW;
    localparam int W4 = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         a_rst_n, a_valid, a_ready, a_mode, a_ovalid, a_olast, a_iready;
    logic [W-1:0] a_data, a_odata;
    logic          b_rst_n, b_valid, b_ready, b_mode, b_ovalid, b_olast, b_iready;
    logic [W4-1:0] b_data, b_odata;

    tpmem_pp #(.BW(BW), .N(N)) u_dut_a (
        .i_clk   (clk),
        .i_Reset (a_rst_n),
        .i_data  (a_data),
        .i_valid (a_valid),
        .o_ready (a_ready),
`ifdef TPMEM_PP_MODE_EN
        .i_mode  (a_mode),
`endif
        .o_data  (a_odata),
        .o_valid (a_ovalid),
        .o_last  (a_olast),
        .i_ready (a_iready)
    );

    tpmem_pp #(.BW(8), .N(4)) u_dut_b (
        .i_clk   (clk),
        .i_Reset (b_rst_n),
        .i_data  (b_data),
        .i_valid (b_valid),
        .o_ready (b_ready),
`ifdef TPMEM_PP_MODE_EN
        .i_mode  (b_mode),
`endif
        .o_data  (b_odata),
        .o_valid (b_ovalid),
        .o_last  (b_olast),
        .i_ready (b_iready)
    );

    logic [W-1:0]  qa_data[$];
    logic          qa_last[$];
    int            qa_cyc[$];
    int            a_acc = 0;
    int            a_stall = 0;
    logic [W4-1:0] b_rows[400];
    logic [W4-1:0] qb_data[$];
    logic          qb_last[$];

    always @(negedge clk) begin
        if (a_ovalid && a_iready) begin
            qa_data.push_back(a_odata);
            qa_last.push_back(a_olast);
            qa_cyc.push_back(cyc);
        end
        if (a_valid && a_ready) a_acc++;
        if (a_valid && !a_ready) a_stall++;
        if (b_ovalid && b_iready) begin
            qb_data.push_back(b_odata);
            qb_last.push_back(b_olast);
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Block blk, row r, element c holds blk*64 + r*8 + c.
    function automatic logic [W-1:0] row_val(input int blk, input int r);
        logic [W-1:0] v;
        for (int c = 0; c < N; c++) v[(N-1-c)*BW +: BW] = BW'(blk * 64 + r * 8 + c);
        return v;
    endfunction

    function automatic logic [W-1:0] col_val(input int blk, input int c);
        logic [W-1:0] v;
        for (int r = 0; r < N; r++) v[(N-1-r)*BW +: BW] = BW'(blk * 64 + r * 8 + c);
        return v;
    endfunction

    task automatic send_row_a(input logic [W-1:0] d, input logic m);
        logic acc;
        bit   done = 1'b0;
        a_data  = d;
        a_mode  = m;
        a_valid = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            acc = a_ready;
            @(posedge clk);
            #1;
            done = acc;
        end
        if (!done) check("send_row_a timeout", 0, 1);
    endtask

    task automatic wait_beats_a(input int n);
        for (int i = 0; i < 300 && qa_data.size() < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_a();
        qa_data.delete();
        qa_last.delete();
        qa_cyc.delete();
    endtask

    task automatic check_blocks_a(input string tag, input int first_blk, input int nblk);
        check({tag, " beat count"}, qa_data.size(), nblk * N);
        for (int j = 0; j < qa_data.size() && j < nblk * N; j++) begin
            check(tag, {qa_last[j], qa_data[j]}, {(j % N) == N - 1, col_val(first_blk + j / N, j % N)});
        end
    endtask

    initial begin
        logic [W-1:0]  lit;
        logic [W4-1:0] exp4;
        logic          prev_rdy;
        bit            found;
        int            c7;

        a_rst_n = 1'b1; a_valid = 1'b0; a_data = '0; a_mode = 1'b0; a_iready = 1'b0;
        b_rst_n = 1'b1; b_valid = 1'b0; b_data = '0; b_mode = 1'b0; b_iready = 1'b0;
        #2;
        a_rst_n = 1'b0;
        b_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset o_valid", a_ovalid, 0);
        check("reset o_last", a_olast, 0);
        check("reset o_data", a_odata, 0);
        check("reset o_ready", a_ready, 1);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;

        // Test 1: single block.
        a_iready = 1'b1;
        for (int r = 0; r < N; r++) send_row_a(row_val(0, r), 1'b0);
        a_valid = 1'b0;
        check("t1 o_valid right after row 7 edge", a_ovalid, 0);
        @(posedge clk);
        #1;
        check("t1 o_valid next cycle", a_ovalid, 1);
        lit = 96'h000_008_010_018_020_028_030_038;
        check("t1 beat0 literal", a_odata, lit);
        wait_beats_a(N);
        repeat (3) @(posedge clk);
        #1;
        check_blocks_a("t1 beat", 0, 1);
        lit = 96'h007_00f_017_01f_027_02f_037_03f;
        if (qa_data.size() == N) check("t1 beat7 literal", qa_data[7], lit);

        // Test 2: four blocks back to back.
        clear_a();
        a_stall = 0;
        for (int b = 1; b <= 4; b++)
            for (int r = 0; r < N; r++) send_row_a(row_val(b, r), 1'b0);
        a_valid = 1'b0;
        wait_beats_a(4 * N);
        check("t2 upstream stalls", a_stall, 0);
        check_blocks_a("t2 beat", 1, 4);
        for (int j = 1; j < qa_cyc.size(); j++) check("t2 contiguous", qa_cyc[j] - qa_cyc[0], j);

        // Test 3: backpressure over three blocks.
        clear_a();
        a_iready = 1'b0;
        a_acc = 0;
        fork
            begin
                for (int b = 10; b <= 12; b++)
                    for (int r = 0; r < N; r++) send_row_a(row_val(b, r), 1'b0);
                a_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 100 && a_acc < 16; i++) begin
                    @(posedge clk);
                    #1;
                end
                @(posedge clk);
                #1;
                for (int i = 0; i < 3; i++) begin
                    check("t3 o_ready low with both banks full", a_ready, 0);
                    check("t3 o_valid held", a_ovalid, 1);
                    check("t3 o_data holds col0", a_odata, col_val(10, 0));
                    @(posedge clk);
                    #1;
                end
                check("t3 accepted rows", a_acc, 16);
                a_iready = 1'b1;
                prev_rdy = 1'b1;
                found = 1'b0;
                for (int i = 0; i < 50 && !found; i++) begin
                    @(negedge clk);
                    if (a_ovalid && a_olast) found = 1'b1;
                    else prev_rdy = a_ready;
                end
                check("t3 last beat seen", found, 1);
                check("t3 o_ready low before last col", prev_rdy, 0);
                check("t3 o_ready high after last col load", a_ready, 1);
            end
        join
        wait_beats_a(3 * N);
        check_blocks_a("t3 beat", 10, 3);

        // Test 5: reset with block 1 partial and column 3 of block 0 in flight.
        clear_a();
        a_iready = 1'b0;
        for (int r = 0; r < N; r++) send_row_a(row_val(20, r), 1'b0);
        for (int r = 0; r < 6; r++) send_row_a(row_val(21, r), 1'b0);
        a_valid = 1'b0;
        a_iready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        a_iready = 1'b0;
        check("t5 pre-reset col3", a_odata, col_val(20, 3));
        check("t5 pre-reset o_valid", a_ovalid, 1);
        #2;
        a_rst_n = 1'b0;
        #1;
        check("t5 async o_valid", a_ovalid, 0);
        check("t5 async o_last", a_olast, 0);
        check("t5 async o_data", a_odata, 0);
        repeat (2) @(posedge clk);
        #1;
        a_rst_n = 1'b1;
        a_iready = 1'b1;
        check("t5 o_ready after release", a_ready, 1);
        clear_a();
        repeat (4) @(posedge clk);
        #1;
        check("t5 no stale beats", qa_data.size(), 0);
        for (int r = 0; r < N; r++) send_row_a(row_val(22, r), 1'b0);
        a_valid = 1'b0;
        wait_beats_a(N);
        repeat (3) @(posedge clk);
        #1;
        check_blocks_a("t5 beat", 22, 1);

`ifdef TPMEM_PP_MODE_EN
        // Test 6: pass-through block then transposed block.
        clear_a();
        for (int r = 0; r < N; r++) send_row_a(row_val(30, r), 1'b1);
        c7 = cyc;
        for (int r = 0; r < N; r++) send_row_a(row_val(31, r), 1'b0);
        a_valid = 1'b0;
        wait_beats_a(2 * N);
        check("t6 beat count", qa_data.size(), 2 * N);
        if (qa_cyc.size() > 0) check("t6 first beat latency", qa_cyc[0], c7 + 1);
        for (int j = 0; j < qa_data.size() && j < 2 * N; j++) begin
            check("t6 beat", {qa_last[j], qa_data[j]},
                  {(j % N) == N - 1, (j < N) ? row_val(30, j) : col_val(31, j - N)});
            if (j > 0) check("t6 contiguous", qa_cyc[j] - qa_cyc[0], j);
        end
`endif

        // Test 4: random handshakes, N=4 BW=8, 100 blocks.
        for (int i = 0; i < 400; i++) b_rows[i] = $urandom;
        fork
            begin
                int  sent;
                logic acc;
                sent = 0;
                for (int i = 0; i < 20000 && sent < 400; i++) begin
                    b_data  = b_rows[sent];
                    b_valid = 1'($urandom_range(0, 1));
                    acc = b_valid && b_ready;
                    @(posedge clk);
                    #1;
                    if (acc) sent++;
                end
                b_valid = 1'b0;
                check("t4 rows sent", sent, 400);
            end
            begin
                for (int i = 0; i < 20000 && qb_data.size() < 400; i++) begin
                    b_iready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                b_iready = 1'b1;
            end
        join
        repeat (20) @(posedge clk);
        #1;
        check("t4 beat count", qb_data.size(), 400);
        for (int k = 0; k < qb_data.size() && k < 400; k++) begin
            exp4 = '0;
            for (int r = 0; r < 4; r++)
                exp4[(3-r)*8 +: 8] = b_rows[(k/4)*4 + r][(3-(k%4))*8 +: 8];
            check("t4 beat", {qb_last[k], qb_data[k]}, {(k % 4) == 3, exp4});
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
